// File: rtl/digit_scan_driver.sv
// Four-digit multiplexed 7-segment driver: hex decode, anode scan, leading-zero
// blanking, with new digit values double-buffered and committed only at frame ends.
module digit_scan_driver #(
  parameter int TICK_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]      AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [15:0]      pending_q, pending_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             commit;
  logic [3:0]       nz;
  logic [3:0]       blank;
  logic [3:0]       digit;
  logic             lit;
  logic [3:0]       an_on;
  logic [6:0]       seg_on;
  logic             dp_on;

  // Low-true {g,f,e,d,c,b,a} patterns.
  function automatic logic [6:0] hex_low(input logic [3:0] h);
    case (h)
      4'h0:    hex_low = 7'b1000000;
      4'h1:    hex_low = 7'b1111001;
      4'h2:    hex_low = 7'b0100100;
      4'h3:    hex_low = 7'b0110000;
      4'h4:    hex_low = 7'b0011001;
      4'h5:    hex_low = 7'b0010010;
      4'h6:    hex_low = 7'b0000010;
      4'h7:    hex_low = 7'b1111000;
      4'h8:    hex_low = 7'b0000000;
      4'h9:    hex_low = 7'b0010000;
      4'hA:    hex_low = 7'b0001000;
      4'hB:    hex_low = 7'b0000011;
      4'hC:    hex_low = 7'b1000110;
      4'hD:    hex_low = 7'b0100001;
      4'hE:    hex_low = 7'b0000110;
      default: hex_low = 7'b0001110;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nz
      assign nz[gi] = |disp_q[4*gi +: 4];
    end
  endgenerate

  // A digit blanks only when it and every digit to its left are zero.
  assign blank[3] = blank_lz & ~nz[3];
  assign blank[2] = blank_lz & ~(nz[3] | nz[2]);
  assign blank[1] = blank_lz & ~(|nz[3:1]);
  assign blank[0] = 1'b0;

  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    commit       = tick && (idx_q == 2'd3) && pend_q;
    frame_done_d = tick && (idx_q == 2'd3);

    pend_d    = pend_q;
    pending_d = pending_q;
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (commit) begin
      disp_d    = pending_q;
      disp_dp_d = pend_dp_q;
      pend_d    = 1'b0;
    end
    // A load coinciding with commit refills the buffer after the old value moves out.
    if (load) begin
      pending_d = data;
      pend_dp_d = dp_in;
      pend_d    = 1'b1;
    end

    digit  = disp_q[{idx_q, 2'b00} +: 4];
    lit    = ~blank[idx_q];
    an_on  = lit ? (4'b0001 << idx_q) : 4'b0000;
    seg_on = lit ? ~hex_low(digit) : 7'b0000000;
    dp_on  = lit & disp_dp_q[idx_q];

    an_d  = AN_ACTIVE_LOW ? ~an_on : an_on;
    seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pend_q       <= 1'b0;
      pending_q    <= 16'h0000;
      pend_dp_q    <= 4'h0;
      disp_q       <= 16'h0000;
      disp_dp_q    <= 4'h0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      pend_dp_q    <= pend_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver with TICK_DIV=4: per-frame expectations queued at load
// time, popped and compared cycle by cycle while the frame is scanned out.
module tb_digit_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int frame  = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpi;
    logic        blz;
    logic [3:0]  an_on;
    logic [27:0] seg;
    logic [3:0]  dp_on;
  } rec_t;

  rec_t q[$];
  rec_t tbl[7];
  rec_t zero_rec, rec_a, rec_b;

  digit_scan_driver #(
    .TICK_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data(data),
    .load(load),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [15:0] d, input logic [3:0] dpi, input logic blz,
                              input logic [3:0] an_on, input logic [27:0] sg,
                              input logic [3:0] dp_on);
    rec_t r;
    r.data  = d;
    r.dpi   = dpi;
    r.blz   = blz;
    r.an_on = an_on;
    r.seg   = sg;
    r.dp_on = dp_on;
    return r;
  endfunction

  // Checks one full displayed frame (16 clocks) against the queue head.
  task automatic run_frame(input bit do_load, input rec_t ld, input bit do_late, input rec_t late);
    rec_t       cur;
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;
    one = 4'b0001;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty frame %0d got empty queue required an entry", frame);
      return;
    end
    cur = q.pop_front();
    blank_lz = cur.blz;
    if (do_load) begin
      data  = ld.data;
      dp_in = ld.dpi;
      load  = 1'b1;
      q.push_back(ld);
    end else if (q.size() == 0) begin
      q.push_back(cur);
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        load    = 1'b0;
        exp_an  = cur.an_on[s] ? ~(one << s) : 4'b1111;
        exp_seg = cur.seg[7*s +: 7];
        exp_dp  = ~cur.dp_on[s];
        exp_fd  = (s == 3) && (c == 3);
        checks++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          errors++;
          $display("FAIL slot_out frame %0d slot %0d cyc %0d got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                   frame, s, c, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
        checks++;
        if (frame_done !== exp_fd) begin
          errors++;
          $display("FAIL frame_done frame %0d slot %0d cyc %0d got %b required %b",
                   frame, s, c, frame_done, exp_fd);
        end
        if (do_late && s == 3 && c == 2) begin
          data  = late.data;
          dp_in = late.dpi;
          load  = 1'b1;
          q.push_back(late);
        end
      end
    end
    $display("frame %0d data=%h blank_lz=%b checked", frame, cur.data, cur.blz);
    frame++;
  endtask

  initial begin
    zero_rec = mk(16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
    tbl[0]   = mk(16'h1234, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    tbl[1]   = mk(16'h0050, 4'b1100, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000);
    tbl[2]   = mk(16'h0000, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000);
    tbl[3]   = mk(16'h89AB, 4'b0100, 1'b0, 4'b1111, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0100);
    tbl[4]   = mk(16'hCDEF, 4'b1001, 1'b1, 4'b1111, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1001);
    tbl[5]   = mk(16'h0607, 4'b1111, 1'b1, 4'b0111, {7'h7F, 7'h02, 7'h40, 7'h78}, 4'b0111);
    tbl[6]   = mk(16'h0001, 4'b0010, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h79}, 4'b0010);
    rec_a    = mk(16'hAAAA, 4'b0000, 1'b0, 4'b1111, {7'h08, 7'h08, 7'h08, 7'h08}, 4'b0000);
    rec_b    = mk(16'hBBBB, 4'b0000, 1'b0, 4'b1111, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b0000);

    data     = 16'h0000;
    load     = 1'b0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_held got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    reset = 1'b1;
    q.push_back(zero_rec);

    run_frame(1'b1, tbl[0], 1'b0, zero_rec);
    for (int i = 1; i < 7; i++) begin
      run_frame(1'b1, tbl[i], 1'b0, zero_rec);
    end

    // AAAA loaded at frame start, BBBB loaded in the very cycle AAAA commits.
    run_frame(1'b1, rec_a, 1'b1, rec_b);
    run_frame(1'b0, zero_rec, 1'b0, zero_rec);
    run_frame(1'b0, zero_rec, 1'b0, zero_rec);

    // Mid-frame reset with a load pending on digit 2.
    data  = 16'h7777;
    dp_in = 4'hF;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_digit2 got an=%b required an=1011", an);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    q.push_back(zero_rec);
    run_frame(1'b0, zero_rec, 1'b0, zero_rec);
    run_frame(1'b0, zero_rec, 1'b0, zero_rec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
